// File: rtl/pol_msg_decode.sv
// Kyber message decode: compresses each coefficient of v - u*s to round(2c/Q) mod 2
// and packs the bits LSB-first into a valid/ready byte stream, ending with a done pulse.
module pol_msg_decode #(
  parameter int Q = 7681,
  parameter int N = 256,
  parameter int W = 16
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] coef,
  input  logic         coef_valid,
  output logic         coef_ready,
  output logic [7:0]   msg_byte,
  output logic         msg_valid,
  input  logic         msg_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int CW = $clog2(N);
  localparam int BW = $clog2(N/8);
  localparam logic [W-1:0] QW  = W'(Q);
  localparam logic [W+1:0] LO4 = (W+2)'(Q);
  localparam logic [W+1:0] HI4 = (W+2)'(3*Q);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;

  logic [CW-1:0] coef_cnt;
  logic [BW-1:0] byte_cnt;
  logic [6:0]    sr;
  logic [2:0]    bit_cnt;
  logic          accept, msg_hs;
  logic [W-1:0]  c_red;
  logic [W+1:0]  c4;
  logic          bit_v, oor;

  assign bit_cnt    = coef_cnt[2:0];
  // Stall only the coefficient that would complete a byte while the previous one is still held.
  assign coef_ready = (state == RUN) && !(bit_cnt == 3'd7 && msg_valid && !msg_ready);
  assign accept     = coef_valid && coef_ready;
  assign msg_hs     = msg_valid && msg_ready;

  assign c_red = (coef >= QW) ? coef - QW : coef;
  assign oor   = (c_red >= QW);
  // 2c' against Q/2 and 3Q/2, scaled by 2 so both bounds are exact integers.
  assign c4    = {c_red, 2'b00};
  assign bit_v = (c4 > LO4) && (c4 < HI4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      coef_cnt  <= '0;
      byte_cnt  <= '0;
      sr        <= '0;
      msg_byte  <= '0;
      msg_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (msg_hs) begin
        msg_valid <= 1'b0;
        byte_cnt  <= byte_cnt + 1'b1;
      end
      if (accept) begin
        coef_cnt <= coef_cnt + 1'b1;
        sr       <= {bit_v, sr[6:1]};
        if (oor) err <= 1'b1;
        if (bit_cnt == 3'd7) begin
          msg_byte  <= {bit_v, sr};
          msg_valid <= 1'b1;
        end
      end
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          err      <= 1'b0;
          coef_cnt <= '0;
          byte_cnt <= '0;
          sr       <= '0;
        end
        RUN:   if (accept && coef_cnt == CW'(N-1)) state <= FLUSH;
        FLUSH: if (msg_hs && byte_cnt == BW'(N/8-1)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pol_msg_decode.sv
// Bench for pol_msg_decode: threshold table, directed corner sequences and randomized
// polynomials checked against a rounding-based reference model and stream scoreboard.
module tb_pol_msg_decode;
  localparam int Q = 7681, N = 256, W = 16;

  logic clk = 0, rst_n = 0, start = 0, coef_valid = 0, msg_ready = 1;
  logic [W-1:0] coef = '0;
  logic coef_ready, msg_valid, busy, done, err;
  logic [7:0] msg_byte;

  int vectors = 0, miscompares = 0;
  int cyc = 0, rmode = 0, release_cyc = 0, done_cnt = 0, stall_seen = 0;
  int first_acc = -1, last_acc = -1, hs_last = 0, done_cyc = 0;
  logic [7:0] got[$];
  logic [W-1:0] acc_q[$];
  logic [W-1:0] cq[N];
  bit chk_pend = 0, prev_hold = 0;
  logic [7:0] chk_exp, prev_byte;

  typedef struct { logic [W-1:0] c; bit b; } vec_t;
  vec_t tbl[16];

  pol_msg_decode #(.Q(Q), .N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef(coef), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .msg_byte(msg_byte), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // round(2c/Q) mod 2 after one conditional subtraction; out-of-range values give 0
  function automatic bit model_bit(int c);
    int r;
    r = (c >= Q) ? c - Q : c;
    if (r >= Q) return 1'b0;
    return 1'(((4*r + Q) / (2*Q)) % 2);
  endfunction

  // Stream monitor: everything seen here is what the next rising edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk_pend = 0;
      prev_hold = 0;
    end else begin
      if (chk_pend) begin
        chk("byte_latency", {msg_valid, msg_byte}, {1'b1, chk_exp});
        chk_pend = 0;
      end
      if (prev_hold) chk("byte_stable", {msg_valid, msg_byte}, {1'b1, prev_byte});
      prev_hold = msg_valid && !msg_ready;
      prev_byte = msg_byte;
      if (msg_valid && msg_ready) begin
        got.push_back(msg_byte);
        hs_last = cyc;
      end
      if (coef_valid && !coef_ready && busy) begin
        stall_seen++;
        chk("stall_at_bit7", acc_q.size() % 8, 7);
      end
      if (coef_valid && coef_ready) begin
        acc_q.push_back(coef);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (acc_q.size() % 8 == 0) begin
          chk_exp = '0;
          for (int j = 0; j < 8; j++) chk_exp[j] = model_bit(int'(acc_q[acc_q.size()-8+j]));
          chk_pend = 1;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: msg_ready = 1'b1;
      1: msg_ready = ($urandom_range(0, 2) != 0);
      default: msg_ready = (got.size() == 0) || (cyc >= release_cyc);
    endcase
  end

  task automatic feed(logic [W-1:0] c, bit gaps);
    bit acc;
    acc = 0;
    if (gaps) while ($urandom_range(0, 3) == 0) begin
      coef_valid = 0;
      @(posedge clk); #1;
    end
    coef_valid = 1;
    coef = c;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = coef_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("coef_accept_timeout", 0, 1);
    coef_valid = 0;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_msg_byte"}, msg_byte, 0);
    chk({nm, "_msg_valid"}, msg_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_coef_ready"}, coef_ready, 0);
  endtask

  task automatic begin_poly(string nm);
    got.delete(); acc_q.delete();
    done_cnt = 0; stall_seen = 0; first_acc = -1;
    release_cyc = cyc + 60;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk({nm, "_busy_after_start"}, busy, 1);
    chk({nm, "_err_cleared"}, err, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_poly(string nm, bit gaps, bit mid_start);
    logic [7:0] eb;
    bit ee;
    ee = 0;
    for (int i = 0; i < N; i++) if (int'(cq[i]) >= 2*Q) ee = 1;
    begin_poly(nm);
    for (int i = 0; i < N; i++) begin
      if (mid_start && i == 40) start = 1;
      feed(cq[i], gaps);
      start = 0;
    end
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_err_at_done"}, err, ee);
    @(negedge clk);
    chk({nm, "_done_after_last_byte"}, done_cyc - hs_last, 1);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_err_sticky"}, err, ee);
    chk({nm, "_byte_count"}, got.size(), N/8);
    chk({nm, "_coef_count"}, acc_q.size(), N);
    for (int k = 0; k < N/8 && k < got.size(); k++) begin
      eb = '0;
      for (int j = 0; j < 8; j++) eb[j] = model_bit(int'(cq[8*k+j]));
      chk({nm, "_byte"}, got[k], eb);
    end
    for (int i = 0; i < N && i < acc_q.size(); i++)
      if (acc_q[i] !== cq[i]) chk({nm, "_coef_order"}, acc_q[i], cq[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gb;
    tbl[0]  = '{16'd1920, 1'b0}; tbl[1]  = '{16'd1921, 1'b1};
    tbl[2]  = '{16'd5760, 1'b1}; tbl[3]  = '{16'd5761, 1'b0};
    tbl[4]  = '{16'd7681, 1'b0}; tbl[5]  = '{16'd0,    1'b0};
    tbl[6]  = '{16'd3840, 1'b1}; tbl[7]  = '{16'd7680, 1'b0};
    tbl[8]  = '{16'd9601, 1'b0}; tbl[9]  = '{16'd9602, 1'b1};
    tbl[10] = '{16'd13441, 1'b1}; tbl[11] = '{16'd13442, 1'b0};
    tbl[12] = '{16'd15361, 1'b0}; tbl[13] = '{16'd1,    1'b0};
    tbl[14] = '{16'd7679, 1'b0}; tbl[15] = '{16'd3841, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1;

    // coef_valid while idle must be ignored
    acc_q.delete(); got.delete();
    coef_valid = 1; coef = 16'd3840;
    repeat (10) begin
      @(negedge clk);
      chk("idle_coef_ready", coef_ready, 0);
    end
    @(posedge clk); #1;
    coef_valid = 0;
    chk("idle_no_accept", acc_q.size(), 0);
    chk("idle_no_byte", got.size(), 0);

    // threshold table
    for (int i = 0; i < N; i++) cq[i] = tbl[i % 16].c;
    run_poly("table", 0, 0);
    if (got.size() == N/8) begin
      chk("table_first_byte", got[0], 8'h46);
      for (int i = 0; i < N; i++) begin
        gb = got[i/8];
        chk("table_bit", gb[i%8], tbl[i % 16].b);
      end
    end

    // full polynomial at full rate
    for (int i = 0; i < N; i++) cq[i] = 16'd3840;
    run_poly("full", 0, 0);
    chk("full_no_bubble", last_acc - first_acc, N-1);
    if (got.size() == N/8) chk("full_last_byte", got[N/8-1], 8'hFF);

    // backpressure after the first byte
    rmode = 2;
    for (int i = 0; i < N; i++) cq[i] = (i % 2) ? 16'd3840 : 16'd0;
    run_poly("bp", 0, 0);
    chk("bp_stalled", stall_seen > 0, 1);
    if (got.size() == N/8) chk("bp_byte", got[5], 8'hAA);
    rmode = 0;

    // out-of-range coefficient, then a clean run clears err
    for (int i = 0; i < N; i++) cq[i] = 16'd3840;
    cq[77] = 16'd16000;
    run_poly("oor", 0, 0);
    cq[77] = 16'd3840;
    run_poly("oor_clear", 0, 0);

    // reset mid-run
    for (int i = 0; i < N; i++) cq[i] = W'($urandom_range(0, Q));
    begin_poly("rst");
    for (int i = 0; i < 100; i++) feed(cq[i], 0);
    rst_n = 0;
    #2;
    chk_reset_vals("midrst_async");
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    @(posedge clk); #1;
    run_poly("after_rst", 0, 0);

    // start while busy is ignored
    for (int i = 0; i < N; i++) cq[i] = W'($urandom_range(0, Q));
    run_poly("start_busy", 0, 1);

    // randomized polynomials with gaps, random backpressure and rare out-of-range values
    rmode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++)
        cq[i] = ($urandom_range(0, 63) == 0) ? W'($urandom_range(0, 3*Q))
                                            : W'($urandom_range(0, Q));
      run_poly("rand", 1, 0);
    end
    rmode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
